// File: rtl/periph_hub.sv
// CPU-side host for the peripheral bus: decodes single load/store requests into
// per-slot select strobes, returns registered read data, and hosts a small interrupt controller.
module periph_hub #(
  parameter int XLEN = 32,
  parameter int NP   = 4,
  parameter int AW   = 8,
  localparam int IW  = $clog2(NP)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic               we,
  input  logic [AW-1:0]      addr,
  input  logic [XLEN-1:0]    wdata,
  output logic               ready,
  output logic [XLEN-1:0]    rdata,
  output logic [NP-1:0]      sel,
  output logic               pwe,
  output logic [AW-2-IW:0]   paddr,
  output logic [XLEN-1:0]    pwdata,
  input  logic [NP*XLEN-1:0] pdout,
  input  logic [NP-1:0]      pirq,
  output logic               irq_out,
  output logic [IW-1:0]      irq_id
);

  typedef enum logic [1:0] {IDLE, SEL, CAP} state_t;

  state_t            state, state_n;
  logic              we_q;
  logic [AW-1:0]     addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [NP-1:0]     pend, en, pirq_q;
  logic [NP-1:0]     rise, ackclr, pend_n, en_n, act;
  logic [IW-1:0]     k, id_n;
  logic              ctrl, ctrl_wr, found;
  logic [XLEN-1:0]   creg, slot, cap;

  assign k      = addr_q[AW-2 -: IW];
  assign ctrl   = addr_q[AW-1];
  assign paddr  = addr_q[AW-2-IW:0];
  assign pwdata = wdata_q;

  always_comb begin
    state_n = state;
    sel     = '0;
    pwe     = 1'b0;
    case (state)
      IDLE: if (req) state_n = SEL;
      SEL: begin
        if (!ctrl) begin
          sel = NP'(1) << k;
          pwe = we_q;
        end
        state_n = CAP;
      end
      CAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Controller register writes commit on the SEL->CAP edge, alongside the peripheral strobe.
  always_comb begin
    ctrl_wr = (state == SEL) && ctrl && we_q;
    ackclr  = '0;
    en_n    = en;
    if (ctrl_wr && addr_q[1:0] == 2'd2) ackclr = wdata_q[NP-1:0];
    if (ctrl_wr && addr_q[1:0] == 2'd1) en_n = wdata_q[NP-1:0];
    rise   = pirq & ~pirq_q;
    pend_n = (pend & ~ackclr) | rise;
    act    = pend_n & en_n;
    id_n   = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NP; i++) begin
      if (act[i] && !found) begin
        id_n  = IW'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    creg = '0;
    case (addr_q[1:0])
      2'd0:    creg[NP-1:0] = pend;
      2'd1:    creg[NP-1:0] = en;
      2'd3:    creg[IW:0]   = {irq_out, irq_id};
      default: creg = '0;
    endcase
    slot = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      if (k == IW'(i)) slot = pdout[i*XLEN +: XLEN];
    end
    if (we_q)      cap = '0;
    else if (ctrl) cap = creg;
    else           cap = slot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready   <= 1'b0;
      rdata   <= '0;
      pirq_q  <= '0;
      pend    <= '0;
      en      <= '0;
      irq_out <= 1'b0;
      irq_id  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      ready <= (state == CAP);
      if (state == CAP) rdata <= cap;
      pirq_q  <= pirq;
      pend    <= pend_n;
      en      <= en_n;
      irq_out <= |act;
      irq_id  <= id_n;
    end
  end

endmodule

// File: tb/tb_periph_hub.sv
// Self-checking bench for periph_hub: scoreboarded read data plus direct strobe/interrupt checks.
`timescale 1ns/1ps
module tb_periph_hub;
  localparam int XLEN = 32, NP = 4, AW = 8, IW = 2;

  logic               clk = 1'b0, rst = 1'b1;
  logic               req = 1'b0, we = 1'b0;
  logic [AW-1:0]      addr = '0;
  logic [XLEN-1:0]    wdata = '0;
  logic               ready, pwe, irq_out;
  logic [XLEN-1:0]    rdata, pwdata;
  logic [NP-1:0]      sel, pirq = '0;
  logic [AW-2-IW:0]   paddr;
  logic [NP*XLEN-1:0] pdout = '0;
  logic [IW-1:0]      irq_id;

  int checks = 0, failures = 0;
  logic [XLEN-1:0] exp_q[$];

  periph_hub #(.XLEN(XLEN), .NP(NP), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .sel(sel), .pwe(pwe), .paddr(paddr),
    .pwdata(pwdata), .pdout(pdout), .pirq(pirq), .irq_out(irq_out), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every ready pulse must match the oldest expected read value.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (exp_q.size() == 0) check("sb_unexpected_ready", 32'd1, 32'd0);
      else check("rdata", rdata, exp_q.pop_front());
    end
  end

  task automatic do_access(input logic w, input logic [7:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rd, input logic [3:0] exp_sel,
                           input logic [3:0] pirq_e0);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    exp_q.push_back(exp_rd);
    @(posedge clk);
    #1 req = 1'b0; pirq = pirq_e0;
    @(negedge clk);
    check("sel", {28'd0, sel}, {28'd0, exp_sel});
    check("pwe", {31'd0, pwe}, {31'd0, w & (exp_sel != 0)});
    if (exp_sel != 0) begin
      check("paddr", {27'd0, paddr}, {27'd0, a[4:0]});
      if (w) check("pwdata", pwdata, d);
    end
    check("ready_sel", {31'd0, ready}, 32'd0);
    @(negedge clk);
    check("sel_cap", {28'd0, sel}, 32'd0);
    check("ready_cap", {31'd0, ready}, 32'd0);
    @(negedge clk);
    check("ready_pulse", {31'd0, ready}, 32'd1);
    @(negedge clk);
    check("ready_end", {31'd0, ready}, 32'd0);
  endtask

  task automatic pulse_irq(input logic [3:0] v);
    @(negedge clk); pirq = v;
    @(negedge clk); pirq = '0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    req = 1'b1; pirq = 4'hF;
    pdout[2*XLEN +: XLEN] = 32'hDEADBEEF;
    pdout[1*XLEN +: XLEN] = 32'h11110000;
    #22;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_sel", {28'd0, sel}, 32'd0);
    check("rst_pwe", {31'd0, pwe}, 32'd0);
    check("rst_paddr", {27'd0, paddr}, 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_irq", {29'd0, irq_out, irq_id}, 32'd0);
    @(negedge clk); rst = 1'b0; req = 1'b0;
    @(negedge clk);
    check("irq_en0", {31'd0, irq_out}, 32'd0);
    do_access(1'b0, 8'h80, 32'd0, 32'h0000000F, 4'h0, 4'hF);
    pirq = '0;

    // Back-to-back reads with req held: second sample at E3.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 8'h40;
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'hCAFEF00D);
    @(posedge clk);
    @(negedge clk); check("b2b_sel1", {28'd0, sel}, 32'h4);
    @(negedge clk); check("b2b_sel1_off", {28'd0, sel}, 32'h0);
    @(negedge clk); check("b2b_ready1", {31'd0, ready}, 32'd1);
    pdout[2*XLEN +: XLEN] = 32'hCAFEF00D;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check("b2b_sel2", {28'd0, sel}, 32'h4);
    check("b2b_ready_low", {31'd0, ready}, 32'd0);
    @(negedge clk);
    @(negedge clk); check("b2b_ready2", {31'd0, ready}, 32'd1);

    do_access(1'b1, 8'h23, 32'h12345678, 32'd0, 4'h2, 4'h0);
    do_access(1'b0, 8'h20, 32'd0, 32'h11110000, 4'h2, 4'h0);

    // Interrupt controller.
    do_access(1'b1, 8'h82, 32'hF, 32'd0, 4'h0, 4'h0);
    do_access(1'b1, 8'h81, 32'hA, 32'd0, 4'h0, 4'h0);
    do_access(1'b0, 8'h81, 32'd0, 32'hA, 4'h0, 4'h0);
    pulse_irq(4'hA);
    check("irq_out_a", {31'd0, irq_out}, 32'd1);
    check("irq_id_a", {30'd0, irq_id}, 32'd1);
    do_access(1'b0, 8'h80, 32'd0, 32'hA, 4'h0, 4'h0);
    do_access(1'b0, 8'h83, 32'd0, 32'h5, 4'h0, 4'h0);
    do_access(1'b1, 8'h82, 32'h2, 32'd0, 4'h0, 4'h0);
    do_access(1'b0, 8'h83, 32'd0, 32'h7, 4'h0, 4'h0);
    do_access(1'b1, 8'h82, 32'h8, 32'd0, 4'h0, 4'h0);
    check("irq_out_clr", {31'd0, irq_out}, 32'd0);
    do_access(1'b0, 8'h83, 32'd0, 32'h0, 4'h0, 4'h0);
    do_access(1'b0, 8'h82, 32'd0, 32'h0, 4'h0, 4'h0);

    // ACK and rising edge on the same bit in the same cycle: set wins.
    pulse_irq(4'h1);
    do_access(1'b1, 8'h82, 32'h1, 32'd0, 4'h0, 4'h1);
    do_access(1'b0, 8'h80, 32'd0, 32'h1, 4'h0, 4'h1);
    // Held level does not re-set after ACK.
    do_access(1'b1, 8'h82, 32'h1, 32'd0, 4'h0, 4'h1);
    do_access(1'b0, 8'h80, 32'd0, 32'h0, 4'h0, 4'h0);

    // Disabling a source leaves it pending.
    pulse_irq(4'h8);
    check("irq_id_3", {29'd0, irq_out, irq_id}, 32'h7);
    do_access(1'b1, 8'h81, 32'h0, 32'd0, 4'h0, 4'h0);
    check("irq_off_en0", {31'd0, irq_out}, 32'd0);
    do_access(1'b0, 8'h80, 32'd0, 32'h8, 4'h0, 4'h0);
    do_access(1'b1, 8'h81, 32'hA, 32'd0, 4'h0, 4'h0);

    // Reset during SEL of a read aborts it.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 8'h40;
    @(posedge clk);
    #1 req = 1'b0; rst = 1'b1;
    #1;
    check("abort_sel", {28'd0, sel}, 32'd0);
    check("abort_irq", {31'd0, irq_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_noready", {31'd0, ready}, 32'd0);
    do_access(1'b0, 8'h81, 32'd0, 32'h0, 4'h0, 4'h0);
    do_access(1'b0, 8'h80, 32'd0, 32'h0, 4'h0, 4'h0);
    do_access(1'b0, 8'h40, 32'd0, 32'hCAFEF00D, 4'h4, 4'h0);

    repeat (3) @(negedge clk);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
